// File: rtl/sound_pkg.sv
// Shared definitions for the sound sequencer.
// Request codes, FSM state encoding and default tone timing.
package sound_pkg;

    localparam logic [1:0] CODE_GO   = 2'b11;
    localparam logic [1:0] CODE_PING = 2'b10;
    localparam logic [1:0] CODE_PONG = 2'b01;
    localparam logic [1:0] CODE_STOP = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int unsigned DEF_TICK_DIV = 12000;

    localparam logic [15:0] DEF_HP_GO   = 16'd2048;
    localparam logic [15:0] DEF_HP_PING = 16'd4096;
    localparam logic [15:0] DEF_HP_PONG = 16'd8192;
    localparam logic [15:0] DEF_HP_STOP = 16'd16384;

    localparam logic [7:0] DEF_DUR_GO   = 8'd200;
    localparam logic [7:0] DEF_DUR_PING = 8'd60;
    localparam logic [7:0] DEF_DUR_PONG = 8'd60;
    localparam logic [7:0] DEF_DUR_STOP = 8'd400 % 256;
    localparam logic [7:0] DEF_GAP_MS   = 8'd20;

    // Request bit index equals its code, so the
    // highest set bit is directly the granted code.
    function automatic logic [1:0] prio_code(
        input logic [3:0] p
    );
        logic [1:0] c;
        c = CODE_STOP;
        priority case (1'b1)
            p[3]:    c = CODE_GO;
            p[2]:    c = CODE_PING;
            p[1]:    c = CODE_PONG;
            default: c = CODE_STOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sound_if.sv
// Game-logic side bundle of the sound sequencer.
// Master = game FSM / collision logic, slave = sequencer.
interface sound_if;
    logic [3:0] req;
    logic       mute;
    logic       sound;
    logic       busy;
    logic [1:0] cur_code;
    logic       done;

    modport master (
        output req, mute,
        input  sound, busy, cur_code, done
    );

    modport slave (
        input  req, mute,
        output sound, busy, cur_code, done
    );
endinterface

// File: rtl/sound_sequencer_tone_divider.sv
// Half-period counter producing the tone square wave.
// Exposes the next tone value so the pin register aligns with it.
module tone_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [15:0] i_hp,
    output logic        o_tone_nxt
);

    logic [15:0] r_hp;
    logic [15:0] r_cnt;
    logic        r_tone;
    logic [15:0] w_hp_d;
    logic [15:0] w_cnt_d;
    logic        w_tone_d;

    // Next-state: load beats clear beats counting.
    always_comb begin
        w_hp_d   = r_hp;
        w_cnt_d  = r_cnt;
        w_tone_d = r_tone;
        if (i_load) begin
            w_hp_d   = i_hp;
            w_cnt_d  = 16'd0;
            w_tone_d = 1'b0;
        end else if (i_clr) begin
            w_cnt_d  = 16'd0;
            w_tone_d = 1'b0;
        end else if (i_en) begin
            if (r_cnt == r_hp - 16'd1) begin
                w_cnt_d  = 16'd0;
                w_tone_d = ~r_tone;
            end else begin
                w_cnt_d  = r_cnt + 16'd1;
            end
        end
    end

    // Counter, half-period and tone registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hp   <= 16'd1;
            r_cnt  <= 16'd0;
            r_tone <= 1'b0;
        end else begin
            r_hp   <= w_hp_d;
            r_cnt  <= w_cnt_d;
            r_tone <= w_tone_d;
        end
    end

    assign o_tone_nxt = w_tone_d;

endmodule

// File: rtl/sound_sequencer.sv
// Sound request arbiter and burst sequencer.
// Latches requests, plays one burst at a time, then a silent gap.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter logic [15:0] HP_GO    = DEF_HP_GO,
    parameter logic [15:0] HP_PING  = DEF_HP_PING,
    parameter logic [15:0] HP_PONG  = DEF_HP_PONG,
    parameter logic [15:0] HP_STOP  = DEF_HP_STOP,
    parameter logic [7:0]  DUR_GO   = DEF_DUR_GO,
    parameter logic [7:0]  DUR_PING = DEF_DUR_PING,
    parameter logic [7:0]  DUR_PONG = DEF_DUR_PONG,
    parameter logic [7:0]  DUR_STOP = DEF_DUR_STOP,
    parameter logic [7:0]  GAP_MS   = DEF_GAP_MS
) (
    input  logic     clk,
    input  logic     rst_n,
    sound_if.slave   bus
);

    localparam int PW =
        (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX =
        PW'(TICK_DIV - 1);

    state_t        r_state;
    state_t        w_state_d;
    logic [3:0]    r_pending;
    logic [3:0]    w_pending_d;
    logic [3:0]    w_gmask;
    logic [1:0]    r_code;
    logic [1:0]    w_code_d;
    logic [1:0]    w_gcode;
    logic [7:0]    r_dur;
    logic [7:0]    w_dur_d;
    logic [7:0]    w_dur_sel;
    logic [15:0]   w_hp_sel;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_d;
    logic          r_done;
    logic          w_done_d;
    logic          r_sound;
    logic          w_grant;
    logic          w_tone_clr;
    logic          w_tick;
    logic          w_last;
    logic          w_tone_nxt;

    assign w_gcode = prio_code(r_pending);
    assign w_tick  = (r_presc == TICK_MAX);
    // Final tick of a phase: a count of 0 or 1
    // both end after the current tick period.
    assign w_last  = w_tick && (r_dur <= 8'd1);

    // Tone timing of the code about to be granted.
    always_comb begin
        w_hp_sel  = HP_STOP;
        w_dur_sel = DUR_STOP;
        unique case (w_gcode)
            CODE_GO: begin
                w_hp_sel  = HP_GO;
                w_dur_sel = DUR_GO;
            end
            CODE_PING: begin
                w_hp_sel  = HP_PING;
                w_dur_sel = DUR_PING;
            end
            CODE_PONG: begin
                w_hp_sel  = HP_PONG;
                w_dur_sel = DUR_PONG;
            end
            default: begin
                w_hp_sel  = HP_STOP;
                w_dur_sel = DUR_STOP;
            end
        endcase
    end

    // FSM next-state, arbitration and tick countdown.
    always_comb begin
        w_state_d  = r_state;
        w_code_d   = r_code;
        w_dur_d    = r_dur;
        w_presc_d  = r_presc;
        w_done_d   = 1'b0;
        w_grant    = 1'b0;
        w_tone_clr = 1'b0;
        w_gmask    = 4'b0000;
        unique case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_grant   = 1'b1;
                    w_gmask   = 4'b0001 << w_gcode;
                    w_code_d  = w_gcode;
                    w_dur_d   = w_dur_sel;
                    w_presc_d = '0;
                    w_state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                w_presc_d = w_tick ? '0 : r_presc + 1'b1;
                if (w_last) begin
                    w_state_d  = ST_GAP;
                    w_dur_d    = GAP_MS;
                    w_tone_clr = 1'b1;
                end else if (w_tick) begin
                    w_dur_d = r_dur - 8'd1;
                end
            end
            ST_GAP: begin
                w_presc_d = w_tick ? '0 : r_presc + 1'b1;
                if (w_last) begin
                    w_state_d = ST_IDLE;
                    w_done_d  = 1'b1;
                end else if (w_tick) begin
                    w_dur_d = r_dur - 8'd1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        // A new request in the grant cycle keeps its bit set.
        w_pending_d = (r_pending & ~w_gmask) | bus.req;
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= 4'b0000;
            r_code    <= CODE_STOP;
            r_dur     <= 8'd0;
            r_presc   <= '0;
            r_done    <= 1'b0;
            r_sound   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_pending <= w_pending_d;
            r_code    <= w_code_d;
            r_dur     <= w_dur_d;
            r_presc   <= w_presc_d;
            r_done    <= w_done_d;
            r_sound   <= w_tone_nxt & ~bus.mute;
        end
    end

    tone_divider u_tone (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_grant),
        .i_clr      (w_tone_clr),
        .i_en       (r_state == ST_PLAY),
        .i_hp       (w_hp_sel),
        .o_tone_nxt (w_tone_nxt)
    );

    assign bus.sound    = r_sound;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.cur_code = r_code;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench for sound_sequencer with shortened timing.
// Stimulus queues expected bursts; a monitor checks each on done.
module tb_sound_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sound_if bus();

    sound_sequencer #(
        .TICK_DIV (10),
        .HP_GO    (16'd2),
        .HP_PING  (16'd5),
        .HP_PONG  (16'd3),
        .HP_STOP  (16'd4),
        .DUR_GO   (8'd1),
        .DUR_PING (8'd3),
        .DUR_PONG (8'd2),
        .DUR_STOP (8'd0),
        .GAP_MS   (8'd1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int code;
        int play;
        int blen;
        int tog;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Hand-computed bursts: TICK_DIV=10, gap = 10 cycles.
    // GO   HP2 DUR1: play 10, toggles at 2,4,6,8 -> 4
    // PING HP5 DUR3: play 30, toggles 5..30     -> 6
    // PONG HP3 DUR2: play 20, toggles 3..18     -> 6
    // STOP HP4 DUR0: play 10, toggles 4,8       -> 2
    task automatic push_go();
        exp_q.push_back('{3, 10, 20, 4});
    endtask
    task automatic push_ping(bit muted);
        exp_q.push_back('{2, 30, 40, muted ? 0 : 6});
    endtask
    task automatic push_pong();
        exp_q.push_back('{1, 20, 30, 6});
    endtask
    task automatic push_stop();
        exp_q.push_back('{0, 10, 20, 2});
    endtask

    int   m_len = 0;
    int   m_tog = 0;
    int   m_hi  = -1;
    int   m_code = 0;
    logic m_pbusy = 1'b0;
    logic m_psnd  = 1'b0;
    exp_t m_e;

    // Monitor: measure each burst, compare when done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) begin
                if (!m_pbusy) begin
                    m_len  = 0;
                    m_tog  = 0;
                    m_hi   = -1;
                    m_code = int'(bus.cur_code);
                end
                if (bus.sound !== m_psnd) m_tog++;
                if (bus.sound) m_hi = m_len;
                m_len++;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("code", m_code, m_e.code);
                    check("busy_len", m_len, m_e.blen);
                    check("toggles", m_tog, m_e.tog);
                    check("gap_quiet",
                          int'(m_hi < m_e.play), 1);
                end
            end
        end
        m_pbusy = bus.busy;
        m_psnd  = bus.sound;
    end

    task automatic pulse(logic [3:0] r);
        @(posedge clk);
        #1 bus.req = r;
        @(posedge clk);
        #1 bus.req = 4'b0000;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) &&
               n < budget) begin
            @(posedge clk);
            n++;
        end
        check("idle_in_budget", int'(n < budget), 1);
        repeat (3) @(posedge clk);
    endtask

    int busy_seen;

    initial begin
        bus.req  = 4'b0000;
        bus.mute = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sound", int'(bus.sound), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_code", int'(bus.cur_code), 0);
        check("rst_pending", int'(dut.r_pending), 0);
        rst_n = 1'b1;

        // Single PING with latency check.
        push_ping(1'b0);
        @(posedge clk);
        #1 bus.req = 4'b0100;
        @(posedge clk);
        #1 bus.req = 4'b0000;
        check("lat_edge0_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        check("lat_edge1_busy", int'(bus.busy), 1);
        check("lat_edge1_code", int'(bus.cur_code), 2);
        wait_idle(200);

        // All four at once: priority order.
        push_go();
        push_ping(1'b0);
        push_pong();
        push_stop();
        pulse(4'b1111);
        wait_idle(400);
        check("all_pending_clear", int'(dut.r_pending), 0);

        // PONG arrives mid-PING: no preemption.
        push_ping(1'b0);
        push_pong();
        pulse(4'b0100);
        repeat (10) @(posedge clk);
        pulse(4'b0010);
        wait_idle(400);

        // Muted PING: same timing, silent pin.
        bus.mute = 1'b1;
        push_ping(1'b1);
        pulse(4'b0100);
        wait_idle(200);
        bus.mute = 1'b0;

        // Reset 12 cycles into a PING with PONG pending.
        pulse(4'b0100);
        repeat (5) @(posedge clk);
        pulse(4'b0010);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_pending", int'(dut.r_pending), 2);
        check("pre_rst_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sound", int'(bus.sound), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_pending", int'(dut.r_pending), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        busy_seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.busy) busy_seen++;
        end
        check("no_replay", busy_seen, 0);

        // Held PING: grants at +1, +42, +83, +124.
        push_ping(1'b0);
        push_ping(1'b0);
        push_ping(1'b0);
        push_ping(1'b0);
        @(posedge clk);
        #1 bus.req = 4'b0100;
        repeat (100) @(posedge clk);
        #1 bus.req = 4'b0000;
        wait_idle(400);
        check("final_queue", exp_q.size(), 0);
        check("final_pending", int'(dut.r_pending), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
